// File: rtl/fetch_sched.sv
// fetch_sched: round-robin fetch scheduler feeding a fixed-latency imem.
// Tracks in-flight tags, buffers returns, and supports per-slot flush.
module fetch_sched #(
  parameter int NUM_REQ   = 8,
  parameter int WORD_W    = 32,
  parameter int MEM_LAT   = 2,
  parameter int BUF_DEPTH = 4,
  localparam int TAG_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*WORD_W-1:0] req_pc,
  input  logic [NUM_REQ-1:0]        flush,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [NUM_REQ-1:0]        busy,
  output logic                      mem_rd_en,
  output logic [WORD_W-1:0]         mem_rd_addr,
  input  logic [WORD_W-1:0]         mem_rd_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [TAG_W-1:0]          out_tag,
  output logic [WORD_W-1:0]         out_pc,
  output logic [WORD_W-1:0]         out_instr
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  typedef struct packed {
    logic              v;
    logic              k;
    logic [TAG_W-1:0]  tag;
    logic [WORD_W-1:0] pc;
  } pipe_t;

  typedef struct packed {
    logic              k;
    logic [TAG_W-1:0]  tag;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fent_t;

  logic [NUM_REQ-1:0] r_busy;
  logic [TAG_W-1:0]   r_rr;
  logic [CW-1:0]      r_cnt;
  pipe_t              r_pipe [MEM_LAT];
  fent_t              r_fifo [BUF_DEPTH];
  logic [PW-1:0]      r_rp;
  logic [PW-1:0]      r_wp;
  logic [CW-1:0]      r_fcnt;

  logic [NUM_REQ-1:0] w_elig;
  logic               w_found;
  logic [TAG_W-1:0]   w_gnt;
  logic               w_issue;
  logic [WORD_W-1:0]  w_pc;
  pipe_t              w_pn   [MEM_LAT];
  fent_t              w_fn   [BUF_DEPTH];
  pipe_t              w_last;
  logic               w_push;
  logic               w_push_k;
  fent_t              w_head;
  logic               w_hv;
  logic               w_pop;
  logic               w_take;
  logic [NUM_REQ-1:0] w_clr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // round-robin search: slots at/after r_rr first, then wrap
  always_comb begin
    w_elig  = req_valid & ~r_busy & ~flush;
    w_found = 1'b0;
    w_gnt   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && w_elig[i] && (TAG_W'(i) >= r_rr)) begin
        w_found = 1'b1;
        w_gnt   = TAG_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && w_elig[i]) begin
        w_found = 1'b1;
        w_gnt   = TAG_W'(i);
      end
    end
  end

  // issue gating on credit, plus memory/ack drive
  always_comb begin
    w_issue     = w_found && (r_cnt < CW'(BUF_DEPTH)) && !rst;
    w_pc        = req_pc[w_gnt*WORD_W +: WORD_W];
    req_ack     = w_issue ? (NUM_REQ'(1) << w_gnt) : '0;
    mem_rd_en   = w_issue;
    mem_rd_addr = w_issue ? {2'b00, w_pc[WORD_W-1:2]} : '0;
  end

  // FIFO head view, pop decision and busy clears
  always_comb begin
    w_last    = r_pipe[MEM_LAT-1];
    w_push    = w_last.v;
    w_push_k  = w_last.k | flush[w_last.tag];
    w_head    = r_fifo[r_rp];
    w_hv      = (r_fcnt != '0);
    out_valid = w_hv && !w_head.k;
    w_take    = out_valid && out_ready;
    w_pop     = w_hv && (w_head.k || out_ready);
    w_clr     = flush;
    if (w_take) w_clr = w_clr | (NUM_REQ'(1) << w_head.tag);
    out_tag   = out_valid ? w_head.tag   : '0;
    out_pc    = out_valid ? w_head.pc    : '0;
    out_instr = out_valid ? w_head.instr : '0;
  end

  // next state of the memory shadow pipe with flush kills
  always_comb begin
    w_pn[0].v   = w_issue;
    w_pn[0].k   = 1'b0;
    w_pn[0].tag = w_gnt;
    w_pn[0].pc  = w_pc;
    for (int s = 1; s < MEM_LAT; s++) begin
      w_pn[s]   = r_pipe[s-1];
      w_pn[s].k = r_pipe[s-1].k | flush[r_pipe[s-1].tag];
    end
  end

  // next state of FIFO storage: kill marks plus the push slot
  always_comb begin
    for (int j = 0; j < BUF_DEPTH; j++) begin
      w_fn[j]   = r_fifo[j];
      w_fn[j].k = r_fifo[j].k | flush[r_fifo[j].tag];
      if (w_push && (PW'(j) == r_wp)) begin
        w_fn[j].k     = w_push_k;
        w_fn[j].tag   = w_last.tag;
        w_fn[j].pc    = w_last.pc;
        w_fn[j].instr = mem_rd_data;
      end
    end
  end

  // arbiter pointer, busy flags and outstanding credit count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr   <= '0;
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_issue)
        r_rr <= (w_gnt == TAG_W'(NUM_REQ - 1)) ? '0 : w_gnt + 1'b1;
      r_busy <= (r_busy & ~w_clr) | req_ack;
      if (w_issue && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (!w_issue && w_pop) r_cnt <= r_cnt - 1'b1;
    end
  end

  // shadow pipe register; reset drops any pre-reset reads
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < MEM_LAT; s++) r_pipe[s] <= '0;
    end else begin
      for (int s = 0; s < MEM_LAT; s++) r_pipe[s] <= w_pn[s];
    end
  end

  // return FIFO storage and pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < BUF_DEPTH; j++) r_fifo[j] <= '0;
      r_rp   <= '0;
      r_wp   <= '0;
      r_fcnt <= '0;
    end else begin
      for (int j = 0; j < BUF_DEPTH; j++) r_fifo[j] <= w_fn[j];
      if (w_push) r_wp <= ptr_inc(r_wp);
      if (w_pop)  r_rp <= ptr_inc(r_rp);
      if (w_push && !w_pop)      r_fcnt <= r_fcnt + 1'b1;
      else if (!w_push && w_pop) r_fcnt <= r_fcnt - 1'b1;
    end
  end

  assign busy = r_busy;

  // credit accounting must keep the FIFO from overflowing
  a_no_ovf: assert property (@(posedge clk) disable iff (rst)
    !(w_push && !w_pop && (r_fcnt == CW'(BUF_DEPTH))));

endmodule

// File: tb/tb_fetch_sched.sv
// tb_fetch_sched: directed scenario bench for fetch_sched.
// Memory model returns 0xC0DE0000 ^ word_addr two cycles after the read.
module tb_fetch_sched;

  logic         clk;
  logic         rst;
  logic [7:0]   req_valid;
  logic [255:0] req_pc;
  logic [7:0]   flush;
  logic [7:0]   req_ack;
  logic [7:0]   busy;
  logic         mem_rd_en;
  logic [31:0]  mem_rd_addr;
  logic [31:0]  mem_rd_data;
  logic         out_valid;
  logic         out_ready;
  logic [2:0]   out_tag;
  logic [31:0]  out_pc;
  logic [31:0]  out_instr;

  int n_checks;
  int n_fail;

  logic [31:0] r_a1;
  logic [31:0] r_a2;

  fetch_sched dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_pc(req_pc), .flush(flush),
    .req_ack(req_ack), .busy(busy),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_tag(out_tag), .out_pc(out_pc), .out_instr(out_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    r_a1 <= mem_rd_addr;
    r_a2 <= r_a1;
  end
  assign mem_rd_data = 32'hC0DE0000 ^ r_a2;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    flush = '0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic drain();
    req_valid = '0;
    flush = '0;
    repeat (8) cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0;
    flush = '0;
    out_ready = 1'b0;
    req_pc = '0;
    cyc();
    cyc();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ack !== 8'h00 || busy !== 8'h00 || mem_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctl got ack=%h busy=%h en=%b want 0", req_ack, busy, mem_rd_en);
    end
    n_checks++;
    if (out_valid !== 1'b0 || out_tag !== 3'd0 || out_pc !== 32'd0 || out_instr !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_out got v=%b tag=%0d pc=%h i=%h want 0", out_valid, out_tag, out_pc, out_instr);
    end
    cyc();
  endtask

  task automatic test_single();
    do_reset();
    out_ready = 1'b1;
    req_valid = 8'h01;
    req_pc[31:0] = 32'h40;
    @(negedge clk);
    n_checks++;
    if (mem_rd_en !== 1'b1 || mem_rd_addr !== 32'h10 || req_ack !== 8'h01) begin
      n_fail++;
      $display("FAIL single_issue got en=%b addr=%h ack=%h want 1 10 01", mem_rd_en, mem_rd_addr, req_ack);
    end
    cyc();
    req_valid = '0;
    for (int t = 1; t <= 3; t++) begin
      @(negedge clk);
      n_checks++;
      if (busy[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL single_busy_T%0d got %b want 1", t, busy[0]);
      end
      if (t < 3) begin
        n_checks++;
        if (out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL single_early_T%0d got out_valid=%b want 0", t, out_valid);
        end
      end
      if (t < 3) cyc();
    end
    n_checks++;
    if (out_valid !== 1'b1 || out_tag !== 3'd0 || out_pc !== 32'h40 || out_instr !== 32'hC0DE0010) begin
      n_fail++;
      $display("FAIL single_deliver got v=%b tag=%0d pc=%h i=%h want 1 0 40 c0de0010", out_valid, out_tag, out_pc, out_instr);
    end
    cyc();
    @(negedge clk);
    n_checks++;
    if (busy[0] !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_after got busy0=%b v=%b want 0 0", busy[0], out_valid);
    end
    drain();
  endtask

  task automatic test_rotation();
    logic [7:0] exp_ack;
    logic [2:0] exp_tag;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) req_pc[i*32 +: 32] = 32'h100 + 32'(4 * i);
    req_valid = 8'hFF;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      exp_ack = 8'h01 << (c % 8);
      n_checks++;
      if (mem_rd_en !== 1'b1 || req_ack !== exp_ack) begin
        n_fail++;
        $display("FAIL rot_grant_c%0d got en=%b ack=%h want 1 %h", c, mem_rd_en, req_ack, exp_ack);
      end
      if (c >= 3) begin
        exp_tag = 3'(c - 3);
        n_checks++;
        if (out_valid !== 1'b1 || out_tag !== exp_tag || out_instr !== (32'hC0DE0040 + 32'(c - 3))) begin
          n_fail++;
          $display("FAIL rot_out_c%0d got v=%b tag=%0d i=%h want 1 %0d", c, out_valid, out_tag, out_instr, exp_tag);
        end
      end
      cyc();
    end
    drain();
  endtask

  task automatic test_credit();
    logic [7:0] exp_ack;
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) req_pc[i*32 +: 32] = 32'h100 + 32'(4 * i);
    req_valid = 8'hFF;
    for (int c = 0; c < 11; c++) begin
      if (c == 7) out_ready = 1'b1;
      @(negedge clk);
      if (c < 4) begin
        exp_ack = 8'h01 << c;
        n_checks++;
        if (mem_rd_en !== 1'b1 || req_ack !== exp_ack) begin
          n_fail++;
          $display("FAIL credit_fill_c%0d got en=%b ack=%h want 1 %h", c, mem_rd_en, req_ack, exp_ack);
        end
      end else if (c < 8) begin
        n_checks++;
        if (mem_rd_en !== 1'b0) begin
          n_fail++;
          $display("FAIL credit_stall_c%0d got en=%b want 0", c, mem_rd_en);
        end
      end else if (c == 8) begin
        n_checks++;
        if (mem_rd_en !== 1'b1 || req_ack !== 8'h10) begin
          n_fail++;
          $display("FAIL credit_resume got en=%b ack=%h want 1 10", mem_rd_en, req_ack);
        end
      end
      if (c == 5 || c == 6) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_tag !== 3'd0 || out_pc !== 32'h100) begin
          n_fail++;
          $display("FAIL credit_hold_c%0d got v=%b tag=%0d pc=%h want 1 0 100", c, out_valid, out_tag, out_pc);
        end
      end
      if (c >= 7) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_tag !== 3'(c - 7) ||
            out_instr !== (32'hC0DE0040 + 32'(c - 7))) begin
          n_fail++;
          $display("FAIL credit_order_c%0d got v=%b tag=%0d i=%h want 1 %0d", c, out_valid, out_tag, out_instr, c - 7);
        end
      end
      cyc();
    end
    drain();
  endtask

  task automatic test_flush_inflight();
    do_reset();
    out_ready = 1'b1;
    req_pc[3*32 +: 32] = 32'h10C;
    req_valid = 8'h08;
    @(negedge clk);
    n_checks++;
    if (req_ack !== 8'h08) begin
      n_fail++;
      $display("FAIL fl_issue got ack=%h want 08", req_ack);
    end
    cyc();
    req_valid = '0;
    flush = 8'h08;
    @(negedge clk);
    n_checks++;
    if (busy[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL fl_busy_T1 got %b want 1", busy[3]);
    end
    cyc();
    flush = '0;
    req_pc[3*32 +: 32] = 32'h200;
    req_valid = 8'h08;
    @(negedge clk);
    n_checks++;
    if (busy[3] !== 1'b0 || req_ack !== 8'h08 || mem_rd_addr !== 32'h80) begin
      n_fail++;
      $display("FAIL fl_reissue got busy3=%b ack=%h addr=%h want 0 08 80", busy[3], req_ack, mem_rd_addr);
    end
    cyc();
    req_valid = '0;
    for (int t = 3; t <= 4; t++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || busy[3] !== 1'b1) begin
        n_fail++;
        $display("FAIL fl_killed_T%0d got v=%b busy3=%b want 0 1", t, out_valid, busy[3]);
      end
      cyc();
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_tag !== 3'd3 || out_pc !== 32'h200 || out_instr !== 32'hC0DE0080) begin
      n_fail++;
      $display("FAIL fl_deliver got v=%b tag=%0d pc=%h i=%h want 1 3 200 c0de0080", out_valid, out_tag, out_pc, out_instr);
    end
    drain();
  endtask

  task automatic test_flush_same_cycle();
    do_reset();
    out_ready = 1'b1;
    req_pc[5*32 +: 32] = 32'h300;
    req_valid = 8'h20;
    flush = 8'h20;
    @(negedge clk);
    n_checks++;
    if (req_ack !== 8'h00 || mem_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL fs_block got ack=%h en=%b want 00 0", req_ack, mem_rd_en);
    end
    cyc();
    flush = '0;
    @(negedge clk);
    n_checks++;
    if (req_ack !== 8'h20 || mem_rd_addr !== 32'hC0) begin
      n_fail++;
      $display("FAIL fs_next got ack=%h addr=%h want 20 c0", req_ack, mem_rd_addr);
    end
    cyc();
    drain();
  endtask

  task automatic test_mid_reset();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) req_pc[i*32 +: 32] = 32'h100 + 32'(4 * i);
    req_valid = 8'h07;
    repeat (3) cyc();
    req_valid = '0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ack !== 8'h00 || busy !== 8'h00 || mem_rd_en !== 1'b0 || mem_rd_addr !== 32'd0 ||
        out_valid !== 1'b0 || out_tag !== 3'd0 || out_pc !== 32'd0 || out_instr !== 32'd0) begin
      n_fail++;
      $display("FAIL mr_zero got ack=%h busy=%h en=%b v=%b tag=%0d pc=%h want all 0", req_ack, busy, mem_rd_en, out_valid, out_tag, out_pc);
    end
    for (int t = 0; t < 5; t++) begin
      cyc();
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL mr_stale_%0d got v=%b want 0", t, out_valid);
      end
    end
    cyc();
    req_valid = 8'h0A;
    @(negedge clk);
    n_checks++;
    if (req_ack !== 8'h02) begin
      n_fail++;
      $display("FAIL mr_rr got ack=%h want 02", req_ack);
    end
    cyc();
    drain();
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_single();
    test_rotation();
    test_credit();
    test_flush_inflight();
    test_flush_same_cycle();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
